// File: rtl/raster_edge_setup_pkg.sv
// Shared raster types: coefficient/edge/vertex typedefs and setup FSM states.
// Default widths for the edge-setup block live here too.
package raster_edge_setup_pkg;

  localparam int RASTER_DATA_BITS = 32;
  localparam int RASTER_PID_BITS  = 8;
  localparam int RASTER_FRAC_BITS = 8;

  typedef logic [RASTER_DATA_BITS-1:0] coef_t;

  // [0]=a, [1]=b, [2]=c
  typedef logic [2:0][RASTER_DATA_BITS-1:0] edge_t;

  // [0]=x, [1]=y
  typedef logic [1:0][RASTER_DATA_BITS-1:0] vtx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_SUM,
    S_NORM,
    S_OUT
  } state_t;

endpackage

// File: rtl/raster_edge_setup_mul.sv
// Registered signed W x W multiplier, 1-cycle latency, holds when disabled.
// Ports: clk, i_en, i_a, i_b -> o_p (2*W signed product).
module raster_edge_setup_mul #(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic signed [W-1:0]   i_a,
  input  logic signed [W-1:0]   i_b,
  output logic signed [2*W-1:0] o_p
);

  logic signed [2*W-1:0] r_p;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_p <= (2*W)'(i_a) * (2*W)'(i_b);
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/raster_edge_setup.sv
// Per-primitive edge setup: a/b/c triplets for E_i = a*x + b*y + c,
// winding-normalised so inside is E_i >= 0; zero-area primitives culled
// or flagged. Ports: clk, reset, valid_in/ready_in/pid_in/vtx_in (input
// handshake), valid_out/ready_out/pid_out/edges_out/degenerate (output
// handshake), cull_count (dropped primitives).
module raster_edge_setup
  import raster_edge_setup_pkg::*;
#(
  parameter int DATA_BITS       = RASTER_DATA_BITS,
  parameter int FRAC_BITS       = RASTER_FRAC_BITS,
  parameter int PID_BITS        = RASTER_PID_BITS,
  parameter bit CULL_DEGENERATE = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic [PID_BITS-1:0]           pid_in,
  input  logic [2:0][1:0][DATA_BITS-1:0] vtx_in,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [PID_BITS-1:0]           pid_out,
  output logic [2:0][2:0][DATA_BITS-1:0] edges_out,
  output logic                          degenerate,
  output logic [31:0]                   cull_count
);

  localparam int D = DATA_BITS;
  localparam int P = 2 * DATA_BITS;
  localparam int A = DATA_BITS + 2;

  typedef logic signed [D-1:0] sc_t;
  typedef logic signed [P-1:0] sp_t;

  state_t r_state;
  state_t w_next;

  logic [2:0][1:0][D-1:0] r_vtx;
  logic [PID_BITS-1:0]    r_pid;
  logic [2:0]             r_cnt;
  sc_t                    r_a [3];
  sc_t                    r_b [3];
  sc_t                    r_c [3];
  sp_t                    r_prod [5];
  logic signed [A-1:0]    r_area;
  logic                   r_deg;
  logic [31:0]            r_cull;

  sc_t                 w_ina [3];
  sc_t                 w_inb [3];
  sc_t                 w_c [3];
  sp_t                 w_pe [6];
  sc_t                 w_ma;
  sc_t                 w_mb;
  sp_t                 w_prod;
  logic                w_men;
  logic signed [A-1:0] w_area;
  logic                w_zero;
  logic                w_neg;
  logic                w_cull;

  // Difference taken one bit wider so it cannot overflow before the shift.
  function automatic sc_t edge_c(input sp_t pa, input sp_t pb);
    logic signed [P:0] d;
    d = {pa[P-1], pa} - {pb[P-1], pb};
    return sc_t'(d >>> FRAC_BITS);
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_ina[i] = vtx_in[(i+1)%3][1] - vtx_in[(i+2)%3][1];
      w_inb[i] = vtx_in[(i+2)%3][0] - vtx_in[(i+1)%3][0];
    end
  end

  // Product p: even -> x_j*y_k, odd -> x_k*y_j, for edge i = p/2.
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    case (r_cnt)
      3'd0: begin w_ma = r_vtx[1][0]; w_mb = r_vtx[2][1]; end
      3'd1: begin w_ma = r_vtx[2][0]; w_mb = r_vtx[1][1]; end
      3'd2: begin w_ma = r_vtx[2][0]; w_mb = r_vtx[0][1]; end
      3'd3: begin w_ma = r_vtx[0][0]; w_mb = r_vtx[2][1]; end
      3'd4: begin w_ma = r_vtx[0][0]; w_mb = r_vtx[1][1]; end
      default: begin w_ma = r_vtx[1][0]; w_mb = r_vtx[0][1]; end
    endcase
  end

  assign w_men = (r_state == S_MUL);

  raster_edge_setup_mul #(
    .W(D)
  ) u_mul (
    .clk  (clk),
    .i_en (w_men),
    .i_a  (w_ma),
    .i_b  (w_mb),
    .o_p  (w_prod)
  );

  // Product 5 is still sitting in the multiplier register during SUM.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_pe[i] = r_prod[i];
    end
    w_pe[5] = w_prod;
    for (int i = 0; i < 3; i++) begin
      w_c[i] = edge_c(w_pe[2*i], w_pe[2*i+1]);
    end
    w_area = A'(w_c[0]) + A'(w_c[1]) + A'(w_c[2]);
  end

  assign w_zero = (r_area == '0);
  assign w_neg  = r_area[A-1];
  assign w_cull = w_zero && CULL_DEGENERATE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    ready_in  = 1'b0;
    valid_out = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ready_in = 1'b1;
        if (valid_in) w_next = S_MUL;
      end
      S_MUL: begin
        if (r_cnt == 3'd5) w_next = S_SUM;
      end
      S_SUM: begin
        w_next = S_NORM;
      end
      S_NORM: begin
        w_next = w_cull ? S_IDLE : S_OUT;
      end
      S_OUT: begin
        valid_out = 1'b1;
        if (ready_out) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          r_vtx <= vtx_in;
          r_pid <= pid_in;
          r_cnt <= 3'd0;
          for (int i = 0; i < 3; i++) begin
            r_a[i] <= w_ina[i];
            r_b[i] <= w_inb[i];
          end
        end
      end
      S_MUL: begin
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt != 3'd0) begin
          r_prod[r_cnt-3'd1] <= w_prod;
        end
      end
      S_SUM: begin
        for (int i = 0; i < 3; i++) begin
          r_c[i] <= w_c[i];
        end
        r_area <= w_area;
      end
      S_NORM: begin
        if (w_neg) begin
          for (int i = 0; i < 3; i++) begin
            r_a[i] <= -r_a[i];
            r_b[i] <= -r_b[i];
            r_c[i] <= -r_c[i];
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_deg  <= 1'b0;
      r_cull <= '0;
    end else if (r_state == S_NORM) begin
      if (w_cull) begin
        r_cull <= r_cull + 32'd1;
      end else begin
        r_deg <= w_zero;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      edges_out[i][0] = r_a[i];
      edges_out[i][1] = r_b[i];
      edges_out[i][2] = r_c[i];
    end
  end

  assign pid_out    = r_pid;
  assign degenerate = r_deg;
  assign cull_count = r_cull;

endmodule
